obstacle_field: RTL



---
 rtl/obstacle_field_if.sv | 8 +
 rtl/obstacle_field.sv | 119 +++++++++++
 2 files changed

// File: rtl/obstacle_field_if.sv
// rtl/obstacle_field_if.sv - spawn request / lane handshake between obstacle field and lane RNG
interface obstacle_field_if;
   logic       spawn_req;
   logic [1:0] lane_in;

   modport master (output spawn_req, input lane_in);
   modport slave  (input spawn_req, output lane_in);
endinterface

// File: rtl/obstacle_field.sv
// rtl/obstacle_field.sv - scrolling 3-lane obstacle field with collision, score and lives
module obstacle_field #(
   parameter int ROWS      = 8,
   parameter int TICK_DIV  = 25000000,
   parameter int SPAWN_GAP = 2,
   parameter int LIVES     = 3,
   parameter int SCORE_W   = 10
) (
   input  logic                clk,
   input  logic                rst,
   obstacle_field_if.master    rng,
   input  logic                start,
   input  logic [1:0]          player_lane,
   output logic [3*ROWS-1:0]   field,
   output logic                hit,
   output logic [SCORE_W-1:0]  score,
   output logic [1:0]          lives,
   output logic                running,
   output logic                game_over
);

   localparam int DIV_W = $clog2(TICK_DIV);
   localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   // spawn_req is registered, so it is decided one cycle before div_cnt==TICK_DIV-2
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(TICK_DIV - 3);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SPAWN_GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

   state_t           state;
   state_t           state_next;
   logic [DIV_W-1:0] div_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             tick;
   logic             occupied;
   logic             collide;
   logic             last_life;
   logic             restart;
   logic [2:0]       bottom;
   logic [2:0]       new_row;

   // tick detection, bottom-row collision test and the row entering at the top
   always_comb begin
      tick      = (state == S_RUN) && (div_cnt == DIV_LAST);
      restart   = start && (state != S_RUN);
      bottom    = field[3*(ROWS-1) +: 3];
      occupied  = |bottom;
      last_life = (lives == 2'd1);
      collide   = 1'b0;
      case (player_lane)
         2'd0:    collide = bottom[0];
         2'd1:    collide = bottom[1];
         2'd2:    collide = bottom[2];
         default: collide = 1'b0;
      endcase
      new_row = 3'b000;
      if (gap_cnt == '0) begin
         case (rng.lane_in)
            2'd0:    new_row = 3'b001;
            2'd1:    new_row = 3'b010;
            2'd2:    new_row = 3'b100;
            default: new_row = 3'b000;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // next-state: start leaves IDLE/OVER, losing the last life ends the run
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (tick && collide && last_life) state_next = S_OVER;
         S_OVER:  if (start) state_next = S_RUN;
         default: state_next = S_IDLE;
      endcase
   end

   // state-decoded status outputs
   always_comb begin
      running   = (state == S_RUN);
      game_over = (state == S_OVER);
   end

   // divider, spawn gap, field shift, score and lives; everything freezes outside RUN
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         field         <= '0;
         score         <= '0;
         lives         <= 2'(LIVES);
         div_cnt       <= '0;
         gap_cnt       <= '0;
         rng.spawn_req <= 1'b0;
         hit           <= 1'b0;
      end else begin
         hit           <= tick && collide;
         rng.spawn_req <= (state == S_RUN) && (div_cnt == DIV_PRE) && (gap_cnt == '0);
         if (state == S_RUN) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
         end
         if (tick) begin
            field   <= {field[3*(ROWS-1)-1:0], new_row};
            gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            if (collide) begin
               lives <= lives - 1'b1;
            end else if (occupied && (score != '1)) begin
               score <= score + 1'b1;
            end
         end
      end
   end

endmodule
